lfsr_rng: RTL
=============

Name: lfsr_rng

Overview:
Parametrised Galois LFSR random-number generator with seed load, lock-up guard and a request/valid handshake. Delivers OUT_W-bit values bounded to [0, limit) by rejection sampling. Replaces the fixed 8-bit LFSR for game logic such as spawn position, item type and timing jitter. The LFSR free-runs every cycle, so player-driven request timing adds entropy.

Parameters:
WIDTH, 16, LFSR state width (>= OUT_W, >= 4)
OUT_W, 8, width of the random output word
TAPS, 16'hB400, Galois feedback mask; default is maximal-length x^16+x^14+x^13+x^11+1
DEFAULT_SEED, 16'hACE1, state loaded on reset or on zero seed; must be non-zero
MAX_TRIES, 4, rejected candidates allowed before fallback (>= 1)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  reset, asynchronous, active-high
seed_load  input  1  load seed into the LFSR this cycle
seed  input  WIDTH  seed value
req  input  1  request one bounded random number
limit  input  OUT_W  exclusive upper bound, sampled with req; 0 = full range
busy  output  1  high while a draw is in progress
valid  output  1  one-cycle pulse when rnd is new
rnd  output  OUT_W  random result, held until the next valid
fallback  output  1  qualifies valid: result came from the MAX_TRIES fallback
bit_out  output  1  state[0], raw serial random bit

Behaviour:
- Reset (async clr=1): state=DEFAULT_SEED, FSM=IDLE, busy=0, valid=0, rnd=0, fallback=0. Reset mid-draw aborts the draw; no valid is produced.
- LFSR step, every cycle that seed_load=0: next = (state>>1) ^ (state[0] ? TAPS : 0).
- seed_load=1 overrides the step: state <= seed, or DEFAULT_SEED if seed==0.
- seed_load during DRAW reloads the state; the draw continues using the new state.
- Candidate: cand = state[OUT_W-1:0], taken from the current registered state.
- FSM states:
  - IDLE: busy=0. If req=1, capture limit into lim_r, clear the try counter, go to DRAW.
  - DRAW: busy=1. Each cycle evaluate cand:
    - Accept if lim_r==0 or cand<lim_r: rnd<=cand, fallback<=0, go to DONE.
    - Otherwise increment the try counter. When the counter reaches MAX_TRIES: rnd<=0, fallback<=1, go to DONE.
  - DONE: valid=1 for exactly one cycle, busy=0. Go to IDLE. A req here is ignored.
- req outside IDLE is ignored, not queued.
- Latency:
  - Req sampled at edge k; first candidate is evaluated in cycle k+1.
  - Acceptance on try t (1-based) gives valid high in the cycle after edge k+t.
  - Worst case is MAX_TRIES+1 cycles from req to valid.
- Simultaneous seed_load and req in IDLE: seed is loaded and req is accepted; the first candidate comes from the loaded seed.
- Comparison is unsigned, OUT_W bits. limit=1 accepts only 0.

Optional Feature:
LFSR_LOCKUP_GUARD_EN
- Defined:
  - Zero seed is replaced by DEFAULT_SEED.
  - If the registered state is ever all-zero (e.g. bad TAPS), the next edge loads DEFAULT_SEED instead of stepping.
- Undefined:
  - seed is loaded verbatim, including 0.
  - An all-zero state stays zero, so every candidate is 0.
  - The zero-seed substitution rule in Behaviour does not apply.

Test Plan:
- Reset, then seed_load=1 seed=16'hACE1, then free-run -> state sequence ACE1, E270, 7138, 389C; bit_out 1,0,0,0.
- Same cycle: seed_load=1 seed=ACE1, req=1 limit=0 -> busy for 1 cycle; valid pulse 2 cycles after the req edge; rnd=8'hE1, fallback=0.
- Same cycle: seed_load=1 seed=ACE1, req=1 limit=8'h80 -> E1 rejected, 70 accepted; valid 3 cycles after the req edge; rnd=8'h70.
- Same as above but limit=1, MAX_TRIES=4 -> E1, 70, 38, 9C all rejected; valid with rnd=0, fallback=1, 5 cycles after the req edge.
- seed_load seed=0 with guard defined -> state ACE1; run 65535 steps -> state returns to ACE1, never 0. Guard undefined -> state stays 0 and a limit=0 draw returns rnd=0.
- Assert clr during DRAW -> busy/valid/rnd clear immediately, state=ACE1; req pulses while busy or in DONE -> exactly one valid per accepted req.

Source files
------------

// File: rtl/lfsr_rng.sv
// Galois LFSR random-number generator with bounded draws by rejection sampling.
// Define LFSR_LOCKUP_GUARD_EN to block the all-zero lock-up state.
module lfsr_rng #(
  parameter int               WIDTH        = 16,
  parameter int               OUT_W        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  parameter int               MAX_TRIES    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] rnd,
  output logic             fallback,
  output logic             bit_out
);

  localparam int CW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } fsm_t;

  fsm_t             fsm, fsm_nx;
  logic [WIDTH-1:0] state, state_nx;
  logic [WIDTH-1:0] step_v, load_v;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] lim_r, lim_nx;
  logic [OUT_W-1:0] rnd_nx;
  logic             fb_nx;
  logic [CW-1:0]    tries, tries_nx;
  logic             accept;

  assign step_v = (state >> 1) ^ (state[0] ? TAPS : '0);

`ifdef LFSR_LOCKUP_GUARD_EN
  assign load_v = (seed == '0) ? DEFAULT_SEED : seed;
`else
  assign load_v = seed;
`endif

  always_comb begin
    state_nx = step_v;
    if (seed_load) begin
      state_nx = load_v;
    end
`ifdef LFSR_LOCKUP_GUARD_EN
    else if (state == '0) begin
      state_nx = DEFAULT_SEED;
    end
`endif
  end

  assign cand   = state[OUT_W-1:0];
  assign accept = (lim_r == '0) || (cand < lim_r);

  always_comb begin
    fsm_nx   = fsm;
    lim_nx   = lim_r;
    tries_nx = tries;
    rnd_nx   = rnd;
    fb_nx    = fallback;
    unique case (fsm)
      IDLE: begin
        if (req) begin
          lim_nx   = limit;
          tries_nx = '0;
          fsm_nx   = DRAW;
        end
      end
      DRAW: begin
        if (accept) begin
          rnd_nx = cand;
          fb_nx  = 1'b0;
          fsm_nx = DONE;
        end else begin
          tries_nx = tries + 1'b1;
          if (tries_nx == CW'(MAX_TRIES)) begin
            rnd_nx = '0;
            fb_nx  = 1'b1;
            fsm_nx = DONE;
          end
        end
      end
      DONE: begin
        fsm_nx = IDLE;
      end
      default: begin
        fsm_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= DEFAULT_SEED;
      fsm      <= IDLE;
      lim_r    <= '0;
      tries    <= '0;
      rnd      <= '0;
      fallback <= 1'b0;
    end else begin
      state    <= state_nx;
      fsm      <= fsm_nx;
      lim_r    <= lim_nx;
      tries    <= tries_nx;
      rnd      <= rnd_nx;
      fallback <= fb_nx;
    end
  end

  assign busy    = (fsm == DRAW);
  assign valid   = (fsm == DONE);
  assign bit_out = state[0];

endmodule
